sha256_block_feeder: RTL and testbench

Message front-end for `sha256_core`. It accepts a 32-bit word stream, applies SHA-256 padding and the 64-bit length field, and assembles 512-bit blocks. It drives the core's `load_i`/`busy_o` handshake and carries the chaining value between blocks. When the final block completes, it presents the 256-bit digest. It sits between the bus-facing register/DMA logic and `sha256_core`.

---
 rtl/sha256_block_feeder.sv | 164 ++++++++++++++++
 tb/tb_sha256_block_feeder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_feeder.sv
// SHA-256 message front-end: packs a 32-bit word stream into padded 512-bit
// blocks, drives the core load/busy handshake and chains state between blocks.
module sha256_block_feeder (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [31:0]  data_i,
    input  logic         valid_i,
    input  logic         last_i,
    input  logic [1:0]   bytes_i,
    output logic         ready_o,
    output logic         core_load_o,
    output logic [511:0] core_data_o,
    output logic [255:0] core_state_o,
    input  logic [255:0] core_state_i,
    input  logic         core_busy_i,
    output logic [255:0] digest_o,
    output logic         done_o
);

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FILL = 3'd1;
    localparam logic [2:0] S_PAD  = 3'd2;
    localparam logic [2:0] S_LEN  = 3'd3;
    localparam logic [2:0] S_LOAD = 3'd4;
    localparam logic [2:0] S_WAIT = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]   r_state;
    logic [31:0]  r_buf [16];
    logic [3:0]   r_widx;
    logic [63:0]  r_len;
    logic [255:0] r_h;
    logic [255:0] r_digest;
    logic         r_pad_pend;
    logic         r_len_pend;
    logic         r_final;
    logic         r_done;

    logic [2:0]   w_nbytes;
    logic [31:0]  w_last_word;
    logic [31:0]  w_word;
    logic [63:0]  w_len_inc;
    logic [3:0]   w_widx_nxt;

    assign w_nbytes   = (bytes_i == 2'd0) ? 3'd4 : {1'b0, bytes_i};
    assign w_widx_nxt = r_widx + 4'd1;

    // Final partial word: keep the valid bytes, append 0x80, zero the rest.
    always_comb begin
        w_last_word = data_i;
        case (bytes_i)
            2'd1:    w_last_word = {data_i[31:24], 24'h800000};
            2'd2:    w_last_word = {data_i[31:16], 16'h8000};
            2'd3:    w_last_word = {data_i[31:8], 8'h80};
            default: w_last_word = data_i;
        endcase
    end

    assign w_word    = last_i ? w_last_word : data_i;
    assign w_len_inc = last_i ? {58'd0, w_nbytes, 3'd0} : 64'd32;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_buf      <= '{default: '0};
            r_widx     <= '0;
            r_len      <= '0;
            r_h        <= IV;
            r_digest   <= '0;
            r_pad_pend <= 1'b0;
            r_len_pend <= 1'b0;
            r_final    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i && !core_busy_i) begin
                        r_h        <= IV;
                        r_len      <= '0;
                        r_widx     <= '0;
                        r_buf      <= '{default: '0};
                        r_pad_pend <= 1'b0;
                        r_len_pend <= 1'b0;
                        r_final    <= 1'b0;
                        r_state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (valid_i) begin
                        r_buf[r_widx] <= w_word;
                        r_widx        <= w_widx_nxt;
                        r_len         <= r_len + w_len_inc;
                        if (last_i && bytes_i == 2'd0)
                            r_pad_pend <= 1'b1;
                        if (r_widx == 4'd15) begin
                            r_state <= S_LOAD;
                            if (last_i)
                                r_len_pend <= 1'b1;
                        end else if (last_i) begin
                            // 0x80 already in word 13: nothing left to pad before the length.
                            r_state <= (w_widx_nxt == 4'd14 && bytes_i != 2'd0) ? S_LEN : S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    r_buf[r_widx] <= r_pad_pend ? 32'h8000_0000 : 32'h0;
                    r_pad_pend    <= 1'b0;
                    r_widx        <= w_widx_nxt;
                    if (r_widx == 4'd13) begin
                        r_state <= S_LEN;
                    end else if (r_widx == 4'd15) begin
                        r_len_pend <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LEN: begin
                    r_buf[14] <= r_len[63:32];
                    r_buf[15] <= r_len[31:0];
                    r_final   <= 1'b1;
                    r_state   <= S_LOAD;
                end
                S_LOAD: begin
                    if (core_busy_i)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!core_busy_i) begin
                        r_h <= core_state_i;
                        if (r_final) begin
                            r_final  <= 1'b0;
                            r_digest <= core_state_i;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (r_len_pend) begin
                            r_len_pend <= 1'b0;
                            r_state    <= S_PAD;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready_o      = (r_state == S_FILL);
    assign core_load_o  = (r_state == S_LOAD);
    assign core_state_o = r_h;
    assign digest_o     = r_digest;
    assign done_o       = r_done;
    assign core_data_o  = {r_buf[0],  r_buf[1],  r_buf[2],  r_buf[3],
                           r_buf[4],  r_buf[5],  r_buf[6],  r_buf[7],
                           r_buf[8],  r_buf[9],  r_buf[10], r_buf[11],
                           r_buf[12], r_buf[13], r_buf[14], r_buf[15]};

endmodule

// File: tb/tb_sha256_block_feeder.sv
// Bench for sha256_block_feeder: behavioural SHA-256 core and a byte-level
// padding/digest reference model, driven with randomized messages.
module tb_sha256_block_feeder;

    typedef logic [7:0] bq_t[$];

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] ABC_DIG = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };
    localparam logic [255:0] M56_DIG = {
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1
    };
    localparam logic [511:0] ABC_BLK  = {32'h61626380, 416'h0, 32'h0, 32'h18};
    localparam logic [511:0] M64_BLK2 = {32'h80000000, 416'h0, 32'h0, 32'h200};
    localparam logic [511:0] M56_BLK2 = {480'h0, 32'h1c0};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam int MAXW = 3000;
    localparam int LAT  = 6;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic [31:0]  data_i = '0;
    logic         valid_i = 1'b0;
    logic         last_i = 1'b0;
    logic [1:0]   bytes_i = '0;
    logic         ready_o;
    logic         core_load_o;
    logic [511:0] core_data_o;
    logic [255:0] core_state_o;
    logic [255:0] core_state_i;
    logic         core_busy_i;
    logic [255:0] digest_o;
    logic         done_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sha256_block_feeder dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .last_i       (last_i),
        .bytes_i      (bytes_i),
        .ready_o      (ready_o),
        .core_load_o  (core_load_o),
        .core_data_o  (core_data_o),
        .core_state_o (core_state_o),
        .core_state_i (core_state_i),
        .core_busy_i  (core_busy_i),
        .digest_o     (digest_o),
        .done_o       (done_o)
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
            t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
            s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
    endfunction

    // Behavioural core: accepts load after busy_delay cycles, busy for LAT+1 cycles.
    logic         c_busy = 1'b0;
    logic [255:0] c_state = '0;
    int           c_cnt = 0;
    int           c_wait = 0;
    int           busy_delay = 0;
    int           n_loads = 0;
    logic [255:0] cap_h = '0;
    logic [511:0] cap_d = '0;
    logic [511:0] cap_log[$];
    logic [511:0] exp_blocks[$];
    logic         prev_load = 1'b0;
    logic [511:0] ld_first = '0;

    assign core_busy_i  = c_busy;
    assign core_state_i = c_state;

    always @(posedge clk) begin
        if (core_load_o && !prev_load)
            ld_first <= core_data_o;
        else if (core_load_o && prev_load)
            check_eq("load_data_stable", core_data_o, ld_first);
        prev_load <= core_load_o;
        if (c_busy) begin
            if (c_cnt == 0) begin
                c_busy  <= 1'b0;
                c_state <= compress(cap_h, cap_d);
            end else begin
                c_cnt <= c_cnt - 1;
            end
        end else if (core_load_o) begin
            if (c_wait < busy_delay) begin
                c_wait <= c_wait + 1;
            end else begin
                c_wait  <= 0;
                c_busy  <= 1'b1;
                c_cnt   <= LAT;
                cap_h   <= core_state_o;
                cap_d   <= core_data_o;
                n_loads <= n_loads + 1;
                cap_log.push_back(core_data_o);
                if (exp_blocks.size() > 0)
                    check_eq("block", core_data_o, exp_blocks.pop_front());
            end
        end else begin
            c_wait <= 0;
        end
    end

    always @(negedge clk)
        if (core_load_o || core_busy_i)
            check_eq("ready_during_core", ready_o, 1'b0);

    function automatic bq_t from_str(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic bq_t rand_msg(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Big-endian word i of the message; bytes past the end are random junk.
    function automatic logic [31:0] word_of(input bq_t m, input int i);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++)
            w = {w[23:0], (4*i + k < m.size()) ? m[4*i + k] : 8'($urandom)};
        return w;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] b);
        int t = 0;
        @(negedge clk);
        data_i = d; valid_i = 1'b1; last_i = l; bytes_i = b;
        while (!ready_o && t < MAXW) begin
            @(negedge clk);
            t++;
        end
        if (t >= MAXW) check_eq("accept_timeout", ready_o, 1'b1);
        @(posedge clk);
        #1 valid_i = 1'b0; last_i = 1'b0;
    endtask

    // abort_at >= 0: return after that many words without waiting for completion.
    task automatic run_msg(input bq_t msg, input int abort_at, output logic [255:0] dig);
        bq_t          p;
        logic [511:0] blk;
        logic [255:0] eh;
        logic [63:0]  bl;
        int           nw, nblk, base, t;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(8'(bl >> (8*k)));
        nblk = p.size() / 64;
        eh = IV;
        exp_blocks.delete();
        for (int bi = 0; bi < nblk; bi++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk = {blk[503:0], p[64*bi + j]};
            exp_blocks.push_back(blk);
            eh = compress(eh, blk);
        end
        nw = (msg.size() + 3) / 4;
        dig = '0;
        t = 0;
        while (core_busy_i && t < MAXW) begin
            @(negedge clk);
            t++;
        end
        base = n_loads;
        @(negedge clk);
        start_i = 1'b1; valid_i = 1'b1; data_i = word_of(msg, 0);
        last_i = (nw == 1); bytes_i = 2'(msg.size());
        check_eq("ready_at_start", ready_o, 1'b0);
        @(negedge clk);
        start_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
        check_eq("ready_after_start", ready_o, 1'b1);
        for (int i = 0; i < nw; i++) begin
            if (abort_at >= 0 && i == abort_at) return;
            send_word(word_of(msg, i), i == nw - 1,
                      (i == nw - 1) ? 2'(msg.size()) : 2'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        if (abort_at >= 0) return;
        t = 0;
        while (!done_o && t < MAXW) begin
            @(negedge clk);
            t++;
        end
        check_eq("done_seen", done_o, 1'b1);
        check_eq("digest", digest_o, eh);
        check_eq("load_count", 512'(n_loads - base), 512'(nblk));
        dig = digest_o;
        @(negedge clk);
        check_eq("done_one_cycle", done_o, 1'b0);
        check_eq("digest_held", digest_o, eh);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, ready_o, 1'b0);
        check_eq({tag, "_load"}, core_load_o, 1'b0);
        check_eq({tag, "_done"}, done_o, 1'b0);
        check_eq({tag, "_data"}, core_data_o, '0);
        check_eq({tag, "_digest"}, digest_o, '0);
        check_eq({tag, "_state"}, core_state_o, IV);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] dig;
        int lens [19] = '{1, 2, 3, 4, 5, 52, 53, 55, 57, 59, 60, 61, 62, 63, 65, 119, 120, 128, 130};
        int t;

        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_i = 1'b0;

        run_msg(from_str("abc"), -1, dig);
        check_eq("abc_digest", dig, ABC_DIG);
        check_eq("abc_block", cap_log[cap_log.size()-1], ABC_BLK);

        run_msg(from_str("abc"), -1, dig);
        check_eq("abc_again_digest", dig, ABC_DIG);

        run_msg(from_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), -1, dig);
        check_eq("m56_digest", dig, M56_DIG);
        check_eq("m56_block2", cap_log[cap_log.size()-1], M56_BLK2);

        run_msg(rand_msg(64), -1, dig);
        check_eq("m64_block2", cap_log[cap_log.size()-1], M64_BLK2);

        busy_delay = 5;
        run_msg(rand_msg(100), -1, dig);
        busy_delay = 0;

        // Reset after seven words of a block.
        run_msg(rand_msg(40), 7, dig);
        @(negedge clk) rst_i = 1'b1;
        @(posedge clk);
        #1 check_reset_outputs("rst_mid_block");
        @(negedge clk) rst_i = 1'b0;
        run_msg(from_str("abc"), -1, dig);
        check_eq("abc_after_rst_digest", dig, ABC_DIG);

        // Reset while load is held against a slow core.
        busy_delay = 5;
        run_msg(rand_msg(64), 16, dig);
        t = 0;
        while (!core_load_o && t < MAXW) begin
            @(negedge clk);
            t++;
        end
        check_eq("load_before_rst", core_load_o, 1'b1);
        rst_i = 1'b1;
        @(posedge clk);
        #1 check_reset_outputs("rst_in_load");
        @(negedge clk) rst_i = 1'b0;
        busy_delay = 0;

        // Reset while the core is busy: start must be ignored until it finishes.
        run_msg(rand_msg(64), 16, dig);
        t = 0;
        while (!core_busy_i && t < MAXW) begin
            @(negedge clk);
            t++;
        end
        check_eq("busy_before_rst", core_busy_i, 1'b1);
        rst_i = 1'b1;
        @(posedge clk);
        #1 check_reset_outputs("rst_in_busy");
        @(negedge clk);
        rst_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check_eq("start_blocked_busy", core_busy_i, 1'b1);
        check_eq("start_blocked_ready", ready_o, 1'b0);
        run_msg(from_str("abc"), -1, dig);
        check_eq("abc_after_busy_rst", dig, ABC_DIG);

        foreach (lens[i]) begin
            busy_delay = $urandom_range(0, 3);
            run_msg(rand_msg(lens[i]), -1, dig);
        end
        for (int i = 0; i < 4; i++) begin
            busy_delay = $urandom_range(0, 3);
            run_msg(rand_msg($urandom_range(1, 200)), -1, dig);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
